// File: rtl/shift_buffer_pkg.sv
// Shared constants for the serial shift buffer: buffer width, sync field geometry
// and the derived frame match mask/value.
package shift_buffer_pkg;

   localparam int unsigned WIDTH    = 64;
   localparam int unsigned HEAD_MSB = 62;
   localparam int unsigned HEAD_W   = 5;
   localparam int unsigned TAIL_MSB = 8;
   localparam int unsigned TAIL_W   = 9;

   // Mask covering bits [msb -: w] of a WIDTH-bit vector.
   function automatic logic [WIDTH-1:0] field_mask(input int unsigned msb, input int unsigned w);
      logic [WIDTH-1:0] ones;
      ones = (WIDTH'(1) << w) - WIDTH'(1);
      return ones << (msb - w + 1);
   endfunction

   localparam logic [WIDTH-1:0] HEAD_MASK   = field_mask(HEAD_MSB, HEAD_W);
   localparam logic [WIDTH-1:0] TAIL_MASK   = field_mask(TAIL_MSB, TAIL_W);
   localparam logic [WIDTH-1:0] MATCH_MASK  = HEAD_MASK | TAIL_MASK;
   // Both sync fields are runs of ones, so the required value equals the mask.
   localparam logic [WIDTH-1:0] MATCH_VALUE = MATCH_MASK;

   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_SHIFT = 2'd1,
      ACT_CLEAR = 2'd2
   } action_e;

endpackage

// File: rtl/shift_buffer_if.sv
// Serial-in / parallel-out bus between a stream source and the shift buffer.
interface shift_buffer_if;
   import shift_buffer_pkg::*;

   logic             en;
   logic             din;
   logic             pkt_rst;
   logic [WIDTH-1:0] dout;
   logic             pkt_rec;

   modport master (output en, din, pkt_rst, input  dout, pkt_rec);
   modport slave  (input  en, din, pkt_rst, output dout, pkt_rec);

endinterface

// File: rtl/shift_buffer_sync_matcher.sv
// Combinational frame detector: head and tail sync fields both present.
module sync_matcher
   import shift_buffer_pkg::*;
(
   input  logic [WIDTH-1:0] vec_i,
   output logic             match_c_o
);

   assign match_c_o = ((vec_i & MATCH_MASK) == MATCH_VALUE);

endmodule

// File: rtl/shift_buffer.sv
// 64-bit serial shift buffer that freezes on a complete sync-framed packet
// until acknowledged with pkt_rst.
module shift_buffer
   import shift_buffer_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   shift_buffer_if.slave  bus
);

   logic [WIDTH-1:0] buf_q, buf_d;
   logic [WIDTH-1:0] shifted;
   logic             pkt_rec_q, pkt_rec_d;
   logic             match_c;
   action_e          action;

   assign shifted = {buf_q[WIDTH-2:0], bus.din};

   // Match is judged on the post-shift value so the flag rises with the last tail bit.
   sync_matcher u_sync_matcher (
      .vec_i     (shifted),
      .match_c_o (match_c)
   );

   // Priority: ack clears, a held packet freezes, otherwise shift on enable.
   always_comb begin
      action    = ACT_HOLD;
      buf_d     = buf_q;
      pkt_rec_d = pkt_rec_q;
      if (bus.pkt_rst) begin
         action = ACT_CLEAR;
      end else if (!pkt_rec_q && bus.en) begin
         action = ACT_SHIFT;
      end
      case (action)
         ACT_CLEAR: begin
            buf_d     = '0;
            pkt_rec_d = 1'b0;
         end
         ACT_SHIFT: begin
            buf_d     = shifted;
            pkt_rec_d = match_c;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q     <= '0;
         pkt_rec_q <= 1'b0;
      end else begin
         buf_q     <= buf_d;
         pkt_rec_q <= pkt_rec_d;
      end
   end

   assign bus.dout    = buf_q;
   assign bus.pkt_rec = pkt_rec_q;

endmodule

// File: tb/tb_shift_buffer.sv
// Self-checking bench for shift_buffer against a bit-history reference model.
module tb_shift_buffer;
   import shift_buffer_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   shift_buffer_if bus ();

   shift_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: received bits in arrival order, plus the sticky flag.
   bit hist[$];
   bit m_rec;

   function automatic logic [63:0] model_dout();
      logic [63:0] v;
      int n;
      v = '0;
      n = hist.size();
      for (int i = 0; i < n && i < 64; i++) v[i] = hist[n-1-i];
      return v;
   endfunction

   task automatic model_edge(input bit r, input bit pr, input bit e, input bit d);
      logic [63:0] v;
      if (r || pr) begin
         hist.delete();
         m_rec = 1'b0;
      end else if (!m_rec && e) begin
         hist.push_back(d);
         if (hist.size() > 64) void'(hist.pop_front());
         v = model_dout();
         if (v[62:58] == 5'h1F && v[8:0] == 9'h1FF) m_rec = 1'b1;
      end
   endtask

   task automatic drive(input bit r, input bit pr, input bit e, input bit d);
      rst         = r;
      bus.pkt_rst = pr;
      bus.en      = e;
      bus.din     = d;
      @(posedge clk);
      model_edge(r, pr, e, d);
      #1;
   endtask

   function automatic logic [63:0] make_frame();
      logic [63:0] f;
      f = {$urandom, $urandom};
      f[63]    = 1'b1;
      f[62:58] = 5'h1F;
      f[8:0]   = 9'h1FF;
      for (int i = 9; i <= 57; i += 8) f[i] = 1'b0;
      return f;
   endfunction

   task automatic test_reset();
      drive(1, 0, 1, 1);
      drive(1, 0, 0, 0);
      checks++;
      if (bus.dout !== 64'h0) begin
         errors++;
         $display("FAIL reset_dout: got %h want %h", bus.dout, 64'h0);
      end
      checks++;
      if (bus.pkt_rec !== 1'b0) begin
         errors++;
         $display("FAIL reset_pkt_rec: got %b want 0", bus.pkt_rec);
      end
   endtask

   task automatic test_shift_pattern();
      logic [7:0] pat;
      pat = 8'b1010_1100;
      for (int i = 7; i >= 0; i--) drive(0, 0, 1, pat[i]);
      checks++;
      if (bus.dout[7:0] !== 8'hAC) begin
         errors++;
         $display("FAIL shift_low_byte: got %h want %h", bus.dout[7:0], 8'hAC);
      end
      checks++;
      if (bus.dout !== model_dout() || bus.pkt_rec !== 1'b0) begin
         errors++;
         $display("FAIL shift_model: got %h/%b want %h/0", bus.dout, bus.pkt_rec, model_dout());
      end
   endtask

   task automatic test_frame(output logic [63:0] f);
      drive(0, 1, 0, 0);
      f = make_frame();
      for (int i = 63; i >= 1; i--) begin
         drive(0, 0, 1, f[i]);
         checks++;
         if (bus.dout !== model_dout() || bus.pkt_rec !== 1'b0) begin
            errors++;
            $display("FAIL frame_stream bit %0d: got %h/%b want %h/0", i, bus.dout, bus.pkt_rec, model_dout());
         end
      end
      drive(0, 0, 1, f[0]);
      checks++;
      if (bus.pkt_rec !== 1'b1 || m_rec !== 1'b1) begin
         errors++;
         $display("FAIL frame_pkt_rec: got %b want 1", bus.pkt_rec);
      end
      checks++;
      if (bus.dout !== f) begin
         errors++;
         $display("FAIL frame_dout: got %h want %h", bus.dout, f);
      end
      checks++;
      if (bus.dout[62:58] !== 5'h1F || bus.dout[8:0] !== 9'h1FF) begin
         errors++;
         $display("FAIL frame_sync_fields: got %h/%h want 1f/1ff", bus.dout[62:58], bus.dout[8:0]);
      end
   endtask

   task automatic test_freeze_and_ack(input logic [63:0] f);
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 1, k[0]);
         checks++;
         if (bus.dout !== f || bus.pkt_rec !== 1'b1) begin
            errors++;
            $display("FAIL freeze cycle %0d: got %h/%b want %h/1", k, bus.dout, bus.pkt_rec, f);
         end
      end
      drive(0, 1, 1, 1);
      checks++;
      if (bus.dout !== 64'h0 || bus.pkt_rec !== 1'b0) begin
         errors++;
         $display("FAIL ack_clear: got %h/%b want 0/0", bus.dout, bus.pkt_rec);
      end
      drive(0, 0, 1, 1);
      checks++;
      if (bus.dout !== 64'h1) begin
         errors++;
         $display("FAIL ack_resume: got %h want %h", bus.dout, 64'h1);
      end
   endtask

   task automatic test_partial_match();
      logic [63:0] f;
      logic [63:0] held;
      // Head field 11110 with a valid tail, plus a mid-stream enable gap.
      drive(0, 1, 0, 0);
      f = make_frame();
      f[58] = 1'b0;
      for (int i = 63; i >= 0; i--) begin
         drive(0, 0, 1, f[i]);
         if (i == 30) begin
            held = bus.dout;
            for (int g = 0; g < 5; g++) begin
               drive(0, 0, 0, 1'($urandom));
               checks++;
               if (bus.dout !== held) begin
                  errors++;
                  $display("FAIL hold_gap %0d: got %h want %h", g, bus.dout, held);
               end
            end
         end
      end
      checks++;
      if (bus.pkt_rec !== 1'b0 || bus.dout !== f) begin
         errors++;
         $display("FAIL tail_only: got %h/%b want %h/0", bus.dout, bus.pkt_rec, f);
      end
      // Head present, tail broken at bit 8.
      drive(0, 1, 0, 0);
      f = make_frame();
      f[8] = 1'b0;
      for (int i = 63; i >= 0; i--) drive(0, 0, 1, f[i]);
      checks++;
      if (bus.pkt_rec !== 1'b0 || bus.dout !== f) begin
         errors++;
         $display("FAIL head_only: got %h/%b want %h/0", bus.dout, bus.pkt_rec, f);
      end
      // Head run shifted down by one position: not an exact field match.
      drive(0, 1, 0, 0);
      f = '0;
      f[61:57] = 5'h1F;
      f[8:0]   = 9'h1FF;
      for (int i = 63; i >= 0; i--) drive(0, 0, 1, f[i]);
      checks++;
      if (bus.pkt_rec !== 1'b0 || bus.dout !== f) begin
         errors++;
         $display("FAIL misaligned_head: got %h/%b want %h/0", bus.dout, bus.pkt_rec, f);
      end
   endtask

   task automatic test_final_bit_override(input bit use_rst);
      logic [63:0] f;
      drive(0, 1, 0, 0);
      f = make_frame();
      for (int i = 63; i >= 1; i--) drive(0, 0, 1, f[i]);
      drive(use_rst, !use_rst, 1, f[0]);
      checks++;
      if (bus.dout !== 64'h0 || bus.pkt_rec !== 1'b0) begin
         errors++;
         $display("FAIL final_bit_%s: got %h/%b want 0/0", use_rst ? "rst" : "pkt_rst", bus.dout, bus.pkt_rec);
      end
      drive(0, 0, 1, 1);
      checks++;
      if (bus.dout !== 64'h1 || bus.pkt_rec !== 1'b0) begin
         errors++;
         $display("FAIL restart_%s: got %h/%b want 1/0", use_rst ? "rst" : "pkt_rst", bus.dout, bus.pkt_rec);
      end
   endtask

   task automatic test_random();
      bit r, pr, e, d;
      for (int c = 0; c < 600; c++) begin
         r  = ($urandom_range(63) == 0);
         pr = ($urandom_range(15) == 0);
         e  = ($urandom_range(7) != 0);
         d  = ($urandom_range(7) != 0);
         drive(r, pr, e, d);
         checks++;
         if (bus.dout !== model_dout() || bus.pkt_rec !== m_rec) begin
            errors++;
            $display("FAIL random cycle %0d: got %h/%b want %h/%b", c, bus.dout, bus.pkt_rec, model_dout(), m_rec);
         end
      end
   endtask

   initial begin
      logic [63:0] frame;
      checks      = 0;
      errors      = 0;
      m_rec       = 1'b0;
      rst         = 1'b1;
      bus.en      = 1'b0;
      bus.din     = 1'b0;
      bus.pkt_rst = 1'b0;
      test_reset();
      test_shift_pattern();
      test_frame(frame);
      test_freeze_and_ack(frame);
      test_partial_match();
      test_final_bit_override(1'b1);
      test_final_bit_override(1'b0);
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
